// File: rtl/home_security_ctrl.sv
// Multi-zone security controller: keypad PIN entry, arm/disarm/change-PIN, entry delay, wrong-PIN lockout.
// Latency: all outputs are registered; inputs sampled at an edge are visible on the outputs after that edge.
// Backpressure: none; every input is consumed every cycle, and commands/digits are dropped while locked out.
module home_security_ctrl #(
   parameter int                      ZONES          = 4,
   parameter int                      PIN_DIGITS     = 4,
   parameter logic [4*PIN_DIGITS-1:0] DEFAULT_PIN    = 16'h1234,
   parameter int                      ENTRY_DELAY    = 8,
   parameter int                      MAX_ATTEMPTS   = 3,
   parameter int                      LOCKOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ZONES-1:0] trigger,
   input  logic [1:0]       command,
   input  logic [3:0]       digit,
   input  logic             input_digit,
   output logic             armed,
   output logic             alarm,
   output logic [3:0]       state,
   output logic [ZONES-1:0] zone_latched,
   output logic             locked_out
);

   localparam int PW = 4 * PIN_DIGITS;
   localparam int CW = $clog2(PIN_DIGITS + 1);
   localparam int AW = $clog2(MAX_ATTEMPTS + 1);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int EW = (ENTRY_DELAY > 0) ? $clog2(ENTRY_DELAY + 1) : 1;
   // Entry timer load value; the zero-delay case never loads it.
   localparam int ENT_LOAD = (ENTRY_DELAY > 0) ? ENTRY_DELAY - 1 : 0;

   localparam logic [1:0] CMD_ARM    = 2'b01;
   localparam logic [1:0] CMD_DISARM = 2'b10;
   localparam logic [1:0] CMD_CHANGE = 2'b11;

   typedef enum logic [3:0] {
      DISARMED = 4'd0,
      ARMED    = 4'd1,
      ENTRY    = 4'd2,
      ALARM    = 4'd3,
      SET_PIN  = 4'd4
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      pin_q, pin_d;
   logic [PW-1:0]      buf_q, buf_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [AW-1:0]      att_q, att_d;
   logic [LW-1:0]      lock_tmr_q, lock_tmr_d;
   logic [EW-1:0]      ent_tmr_q, ent_tmr_d;
   logic [ZONES-1:0]   zone_q, zone_d;
   logic               lock_q, lock_d;
   logic               armed_q, armed_d;
   logic               alarm_q, alarm_d;

   logic               cnt_full;
   logic               pin_ok;
   logic               cmd_eval;
   logic               applies;
   logic               disarm_ok;

   assign cnt_full = (cnt_q == CW'(PIN_DIGITS));
   assign pin_ok   = cnt_full && (buf_q == pin_q);
   assign cmd_eval = !lock_q && (command != 2'b00);

   // State register and all datapath registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= DISARMED;
         pin_q      <= DEFAULT_PIN;
         buf_q      <= '0;
         cnt_q      <= '0;
         att_q      <= '0;
         lock_tmr_q <= '0;
         ent_tmr_q  <= '0;
         zone_q     <= '0;
         lock_q     <= 1'b0;
         armed_q    <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pin_q      <= pin_d;
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         att_q      <= att_d;
         lock_tmr_q <= lock_tmr_d;
         ent_tmr_q  <= ent_tmr_d;
         zone_q     <= zone_d;
         lock_q     <= lock_d;
         armed_q    <= armed_d;
         alarm_q    <= alarm_d;
      end
   end

   // Next-state logic: command evaluation, digit buffer, attempts/lockout, then zones and entry timer.
   always_comb begin
      state_d    = state_q;
      pin_d      = pin_q;
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      att_d      = att_q;
      lock_tmr_d = lock_tmr_q;
      ent_tmr_d  = ent_tmr_q;
      zone_d     = zone_q;
      lock_d     = lock_q;
      applies    = 1'b0;
      disarm_ok  = 1'b0;

      if (cmd_eval) begin
         case (state_q)
            DISARMED: begin
               if (command == CMD_ARM || command == CMD_CHANGE) begin
                  applies = 1'b1;
                  if (pin_ok) state_d = (command == CMD_ARM) ? ARMED : SET_PIN;
               end
            end
            ARMED, ENTRY, ALARM: begin
               if (command == CMD_DISARM) begin
                  applies = 1'b1;
                  if (pin_ok) begin
                     disarm_ok = 1'b1;
                     state_d   = DISARMED;
                  end
               end
            end
            SET_PIN: begin
               if (command == CMD_CHANGE && cnt_full) begin
                  pin_d   = buf_q;
                  state_d = DISARMED;
               end else if (command == CMD_DISARM) begin
                  state_d = DISARMED;
               end
            end
            default: state_d = DISARMED;
         endcase
         // Any evaluated command consumes the buffer; a same-cycle digit is dropped.
         buf_d = '0;
         cnt_d = '0;
      end else if (lock_q) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (input_digit) begin
         if (digit <= 4'd9) begin
            buf_d = PW'({buf_q, digit});
            cnt_d = cnt_full ? cnt_q : cnt_q + CW'(1);
         end else begin
            buf_d = '0;
            cnt_d = '0;
         end
      end

      // Wrong-PIN accounting; only commands meaningful in the current state count.
      if (applies) begin
         if (pin_ok) begin
            att_d = '0;
         end else if (att_q == AW'(MAX_ATTEMPTS - 1)) begin
            att_d      = '0;
            lock_d     = 1'b1;
            lock_tmr_d = LW'(LOCKOUT_CYCLES - 1);
         end else begin
            att_d = att_q + AW'(1);
         end
      end

      if (lock_q) begin
         if (lock_tmr_q == '0) lock_d = 1'b0;
         else                  lock_tmr_d = lock_tmr_q - LW'(1);
      end

      // A successful disarm overrides both the entry timeout and new triggers.
      if (disarm_ok) begin
         zone_d = '0;
      end else begin
         case (state_q)
            ARMED: begin
               zone_d = zone_q | trigger;
               if (|trigger) begin
                  if (ENTRY_DELAY == 0) begin
                     state_d = ALARM;
                  end else begin
                     state_d   = ENTRY;
                     ent_tmr_d = EW'(ENT_LOAD);
                  end
               end
            end
            ENTRY: begin
               zone_d = zone_q | trigger;
               if (ent_tmr_q == '0) state_d = ALARM;
               else                 ent_tmr_d = ent_tmr_q - EW'(1);
            end
            ALARM: zone_d = zone_q | trigger;
            default: ;
         endcase
      end

      armed_d = (state_d == ARMED) || (state_d == ENTRY) || (state_d == ALARM);
      alarm_d = (state_d == ALARM);
   end

   assign state        = state_q;
   assign armed        = armed_q;
   assign alarm        = alarm_q;
   assign zone_latched = zone_q;
   assign locked_out   = lock_q;

endmodule

// File: tb/tb_home_security_ctrl.sv
// Testbench for home_security_ctrl: directed scenarios followed by randomized keypad/sensor traffic.
// Every cycle's outputs are compared against a queue-based behavioural model driven by absolute edge counts.
// No backpressure; the bench drives one input vector per clock.
module tb_home_security_ctrl;

   localparam int PD = 4;
   localparam int ED = 8;
   localparam int MA = 3;
   localparam int LC = 16;

   logic       clk;
   logic       reset;
   logic [3:0] trigger;
   logic [1:0] command;
   logic [3:0] digit;
   logic       input_digit;
   logic       armed;
   logic       alarm;
   logic [3:0] state;
   logic [3:0] zone_latched;
   logic       locked_out;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int         m_state;
   int         m_att;
   int         m_lock_end;
   int         m_alarm_edge;
   int         edge_n;
   logic [3:0] m_zones;
   int         m_pin[$];
   int         m_buf[$];

   home_security_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .trigger      (trigger),
      .command      (command),
      .digit        (digit),
      .input_digit  (input_digit),
      .armed        (armed),
      .alarm        (alarm),
      .state        (state),
      .zone_latched (zone_latched),
      .locked_out   (locked_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_reset();
      m_state      = 0;
      m_att        = 0;
      m_lock_end   = -1;
      m_alarm_edge = -1;
      m_zones      = '0;
      m_buf.delete();
      m_pin = '{1, 2, 3, 4};
   endtask

   function automatic bit buf_matches_pin();
      if (m_buf.size() != PD) return 1'b0;
      for (int i = 0; i < PD; i++)
         if (m_buf[i] != m_pin[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wrong_pin();
      m_att++;
      if (m_att == MA) begin
         m_att      = 0;
         m_lock_end = edge_n + LC;
      end
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_step(input bit rs, input logic [3:0] tr, input int cm, input int dg, input bit dv);
      bit locked, ok, dis_ok, armed_like;
      int nstate;
      edge_n++;
      if (rs) begin
         model_reset();
         return;
      end
      locked     = (edge_n <= m_lock_end);
      ok         = buf_matches_pin();
      nstate     = m_state;
      dis_ok     = 1'b0;
      armed_like = (m_state >= 1 && m_state <= 3);

      if (!locked && cm != 0) begin
         if (m_state == 0) begin
            if (cm == 1 || cm == 3) begin
               if (ok) begin m_att = 0; nstate = (cm == 1) ? 1 : 4; end
               else wrong_pin();
            end
         end else if (armed_like) begin
            if (cm == 2) begin
               if (ok) begin m_att = 0; nstate = 0; dis_ok = 1'b1; end
               else wrong_pin();
            end
         end else begin
            if (cm == 3 && m_buf.size() == PD) begin m_pin = m_buf; nstate = 0; end
            else if (cm == 2) nstate = 0;
         end
         m_buf.delete();
      end else if (locked) begin
         m_buf.delete();
      end else if (dv) begin
         if (dg <= 9) begin
            m_buf.push_back(dg);
            if (m_buf.size() > PD) void'(m_buf.pop_front());
         end else begin
            m_buf.delete();
         end
      end

      if (dis_ok) begin
         m_zones = '0;
      end else if (armed_like) begin
         m_zones = m_zones | tr;
         if (m_state == 2 && edge_n == m_alarm_edge) begin
            nstate = 3;
         end else if (m_state == 1 && tr != 0) begin
            nstate       = (ED == 0) ? 3 : 2;
            m_alarm_edge = edge_n + ED;
         end
      end
      m_state = nstate;
   endtask

   task automatic check_outputs();
      check("state", state, m_state);
      check("armed", armed, (m_state >= 1 && m_state <= 3));
      check("alarm", alarm, (m_state == 3));
      check("zones", zone_latched, m_zones);
      check("locked", locked_out, (edge_n < m_lock_end));
   endtask

   task automatic step(input logic [3:0] tr, input logic [1:0] cm, input logic [3:0] dg,
                       input logic dv, input logic rs);
      trigger     = tr;
      command     = cm;
      digit       = dg;
      input_digit = dv;
      reset       = rs;
      @(posedge clk);
      model_step(rs, tr, cm, dg, dv);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 2'd0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      step(4'd0, 2'd0, 4'(a), 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'(b), 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'(c), 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'(d), 1'b1, 1'b0);
   endtask

   task automatic cmd(input int c);
      step(4'd0, 2'(c), 4'd0, 1'b0, 1'b0);
   endtask

   function automatic logic [3:0] rtrig();
      return ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'd0;
   endfunction

   initial begin
      edge_n = 0;
      model_reset();
      trigger = '0; command = '0; digit = '0; input_digit = 1'b0; reset = 1'b1;

      step(4'd0, 2'd0, 4'd0, 1'b0, 1'b1);
      step(4'd0, 2'd0, 4'd0, 1'b0, 1'b1);
      check("rst_state", state, 0);
      check("rst_zones", zone_latched, 0);

      // Arm and disarm with the default PIN.
      enter4(1, 2, 3, 4); cmd(1);
      check("arm_state", state, 1);
      check("arm_armed", armed, 1);
      enter4(1, 2, 3, 4); cmd(2);
      check("disarm_state", state, 0);

      // Entry delay runs out into ALARM; zones accumulate.
      enter4(1, 2, 3, 4); cmd(1);
      step(4'b0100, 2'd0, 4'd0, 1'b0, 1'b0);
      check("entry_state", state, 2);
      check("entry_zones", zone_latched, 4'b0100);
      idle(ED - 1);
      check("alarm_before", alarm, 0);
      idle(1);
      check("alarm_after", alarm, 1);
      step(4'b0001, 2'd0, 4'd0, 1'b0, 1'b0);
      check("alarm_zones", zone_latched, 4'b0101);
      enter4(1, 2, 3, 4); cmd(2);
      check("alarm_disarm", state, 0);
      check("alarm_disarm_z", zone_latched, 0);

      // Correct disarm on the timeout edge wins.
      enter4(1, 2, 3, 4); cmd(1);
      step(4'b0010, 2'd0, 4'd0, 1'b0, 1'b0);
      idle(3);
      enter4(1, 2, 3, 4); cmd(2);
      check("race_state", state, 0);
      check("race_alarm", alarm, 0);

      // Lockout after three wrong PINs.
      for (int k = 0; k < 3; k++) begin enter4(1, 2, 3, 5); cmd(1); end
      check("lock_set", locked_out, 1);
      enter4(1, 2, 3, 4); cmd(1);
      check("lock_ignore", state, 0);
      idle(LC - 6);
      check("lock_last", locked_out, 1);
      idle(1);
      check("lock_clear", locked_out, 0);
      enter4(1, 2, 3, 4); cmd(1);
      check("lock_rearm", state, 1);
      enter4(1, 2, 3, 4); cmd(2);

      // Invalid digit clears the buffer; a same-cycle digit is dropped.
      step(4'd0, 2'd0, 4'd1, 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'd2, 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'd15, 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'd3, 1'b1, 1'b0);
      step(4'd0, 2'd0, 4'd4, 1'b1, 1'b0);
      cmd(1);
      check("short_pin", state, 0);
      enter4(1, 2, 3, 4);
      step(4'd0, 2'd1, 4'd5, 1'b1, 1'b0);
      check("same_cyc_dig", state, 1);
      enter4(1, 2, 3, 4); cmd(2);

      // PIN change, then attempt counter cleared by a good PIN.
      enter4(1, 2, 3, 4); cmd(3);
      check("setpin_enter", state, 4);
      enter4(9, 8, 7, 6); cmd(3);
      check("setpin_store", state, 0);
      enter4(1, 2, 3, 4); cmd(1);
      check("old_pin", state, 0);
      enter4(9, 8, 7, 6); cmd(1);
      check("new_pin", state, 1);
      enter4(9, 8, 7, 6); cmd(2);
      enter4(1, 2, 3, 4); cmd(1);
      enter4(1, 2, 3, 4); cmd(1);
      check("att_cleared", locked_out, 0);
      enter4(9, 8, 7, 6); cmd(1);
      check("att_rearm", state, 1);

      // Reset from ALARM restores the default PIN.
      step(4'b1000, 2'd0, 4'd0, 1'b0, 1'b0);
      idle(ED);
      check("pre_rst_alarm", alarm, 1);
      step(4'd0, 2'd0, 4'd0, 1'b0, 1'b1);
      check("rst_alarm", alarm, 0);
      check("rst_armed", armed, 0);
      check("rst_st2", state, 0);
      enter4(1, 2, 3, 4); cmd(1);
      check("rst_pin", state, 1);
      enter4(1, 2, 3, 4); cmd(2);

      // Randomized traffic against the model.
      for (int t = 0; t < 400; t++) begin
         int p[$];
         int n;
         if ($urandom_range(0, 2) != 0) begin
            p = m_pin;
            for (int i = 0; i < p.size(); i++) step(rtrig(), 2'd0, 4'(p[i]), 1'b1, 1'b0);
         end else begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++)
               step(rtrig(), 2'd0,
                    ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                    ($urandom_range(0, 7) != 0), 1'b0);
         end
         step(rtrig(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
         n = $urandom_range(0, 10);
         for (int i = 0; i < n; i++) step(rtrig(), 2'd0, 4'd0, 1'b0, 1'b0);
         if ($urandom_range(0, 60) == 0) step(4'd0, 2'd0, 4'd0, 1'b0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/home_security_ctrl.md
# home_security_ctrl

Parametrised multi-zone home security controller: the next generation of the single-trigger alarm block, with N sensor zones, a configurable PIN length, a changeable PIN, an entry-delay timer and a wrong-PIN lockout. It sits between the keypad/sensor front end and the siren/status outputs. Its `state` output is exported so an equivalence harness can compare it cycle-by-cycle against a reference model.

## Interface
- `ZONES`, default 4: number of sensor zones (1..16).
- `PIN_DIGITS`, default 4: PIN length in BCD digits (1..8).
- `DEFAULT_PIN`, default 16'h1234: PIN loaded at reset, `4*PIN_DIGITS` bits, first-entered digit in the MSBs.
- `ENTRY_DELAY`, default 8: cycles from trigger to alarm (0 = immediate).
- `MAX_ATTEMPTS`, default 3: consecutive wrong PINs that cause a lockout (>=1).
- `LOCKOUT_CYCLES`, default 16: lockout duration in cycles (>=1).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `trigger` in ZONES: per-zone sensor, level-sampled every cycle.
- `command` in 2: 00 none, 01 arm, 10 disarm, 11 change PIN.
- `digit` in 4: keypad digit, valid when `input_digit`=1.
- `input_digit` in 1: digit strobe, one digit per cycle.
- `armed` out 1: high in ARMED, ENTRY and ALARM.
- `alarm` out 1: high in ALARM.
- `state` out 4: DISARMED=0, ARMED=1, ENTRY=2, ALARM=3, SET_PIN=4.
- `zone_latched` out ZONES: zones that tripped since the last disarm.
- `locked_out` out 1: lockout active.

## Operation
- Reset values: state DISARMED; armed=0, alarm=0, zone_latched=0, locked_out=0; PIN=DEFAULT_PIN; digit buffer, digit count, attempts and timers all 0.
- Digit buffer:
  - On `input_digit` with `digit`<=9: shift the digit in at the LSB end; count saturates at PIN_DIGITS; older digits fall off the MSB end.
  - On `input_digit` with `digit`>9: clear buffer and count.
- Command evaluation (`command`!=0):
  - The command uses the buffer contents before this cycle's digit; a digit presented in the same cycle is dropped.
  - Buffer and count are cleared after every evaluated command.
  - PIN ok = (count==PIN_DIGITS) && buffer==PIN.
- Commands by state:
  - DISARMED: arm+ok -> ARMED. change+ok -> SET_PIN. Disarm is ignored; it counts neither as an attempt nor as a reset.
  - ARMED/ENTRY/ALARM: disarm+ok -> DISARMED and clears zone_latched. Arm and change are ignored.
  - SET_PIN: change with count==PIN_DIGITS stores the buffer as the new PIN -> DISARMED. Disarm -> DISARMED, PIN unchanged. Other commands are ignored. SET_PIN evaluation never counts attempts.
- Attempts:
  - A command that applies in the current state (per the list above) with PIN not ok increments attempts.
  - On reaching MAX_ATTEMPTS: locked_out=1, attempts=0, lockout timer started.
  - PIN ok clears attempts.
- Lockout: all commands and digits are ignored and the buffer is held cleared. Triggers and the entry timer keep operating.
- Zones:
  - In ARMED, any trigger bit -> ENTRY (or ALARM if ENTRY_DELAY=0).
  - In ARMED/ENTRY/ALARM, zone_latched |= trigger every cycle.
  - In DISARMED/SET_PIN, triggers are ignored.
- ALARM is left only by a successful disarm.
- Priority at one edge: reset > successful disarm > entry timeout > trigger.

## Timing
- All outputs are registered; inputs sampled at edge E appear on outputs after E.
- Entry:
  - Trigger at edge E in ARMED: state=ENTRY, timer=ENTRY_DELAY-1.
  - Each later edge: timer==0 -> ALARM, else decrement.
  - alarm rises after edge E+ENTRY_DELAY.
- A correct disarm on the timeout edge wins; alarm never asserts.
- Lockout: the wrong-PIN edge L sets locked_out; it clears after edge L+LOCKOUT_CYCLES. The first command accepted is at edge L+LOCKOUT_CYCLES+1.
- Reset mid-operation (any state, lockout, or SET_PIN) restores every reset value at the next edge, including PIN=DEFAULT_PIN.
- Counter widths: `$clog2(max+1)`; no wrap-around.

## Test plan
- Digits 1,2,3,4 then arm -> state=1, armed=1. Digits 1,2,3,4 then disarm -> state=0, zone_latched=0.
- Armed, trigger=4'b0100 for one cycle at edge E -> state=2, zone_latched=0100; alarm=1 after edge E+8. trigger=0001 during ALARM -> zone_latched=0101.
- Armed, trigger at E, correct disarm at edge E+8 -> state=0, alarm never 1.
- Three arms with PIN 1,2,3,5 -> locked_out=1 after the third. Correct PIN plus arm during the next 16 cycles -> ignored. After lockout clears, correct arm -> ARMED.
- PIN 1,2,3,4 + change -> state=4. Digits 9,8,7,6 + change -> state=0. Old PIN + arm -> attempts=1. 9,8,7,6 + arm -> ARMED, attempts=0.
- Digits 1,2 then digit 15 then 3,4 + arm -> rejected (count=2). 1,2,3,4 + arm with a same-cycle digit 5 -> accepted. Reset in ALARM -> all outputs 0, PIN=1234.
